// File: rtl/pipe_hazard_ctl.sv
// Issue/interlock controller for the 4-stage 16-bit pipeline: shadow scoreboard of in-flight
// destinations, RAW stall, branch squash, trap drain to halt and a saturating stall counter.
module pipe_hazard_ctl #(
  parameter int unsigned NREG = 16,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s0_valid,
  input  logic            s0_use_d,
  input  logic            s0_use_s,
  input  logic [3:0]      s0_d,
  input  logic [3:0]      s0_s,
  input  logic            s0_wr,
  input  logic            s0_ctl,
  input  logic            s0_trap,
  input  logic            s2_taken,
  output logic            fetch_en,
  output logic            issue,
  output logic            stall,
  output logic            squash,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  localparam logic [CNTW-1:0] CntOne = {{(CNTW-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic       v;
    logic       wr;
    logic       ctl;
    logic       trap;
    logic [3:0] dst;
  } shadow_t;

  shadow_t s1_q, s1_d;
  shadow_t s2_q, s2_d;

  // Control-transfer flag is dead once an instruction leaves stage 2.
  logic       s3_v_q, s3_wr_q, s3_trap_q;
  logic [3:0] s3_dst_q;

  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [15:0] busy;
  logic        run;
  logic        hit_d, hit_s;
  logic        squash_c, stall_c, issue_c, fetch_c;
  logic        trap_squashed;

  // Pending-write map; registers outside NREG are never tracked.
  always_comb begin
    busy = '0;
    if (s1_q.v && s1_q.wr && (32'(s1_q.dst) < NREG)) busy[s1_q.dst] = 1'b1;
    if (s2_q.v && s2_q.wr && (32'(s2_q.dst) < NREG)) busy[s2_q.dst] = 1'b1;
    if (s3_v_q && s3_wr_q && (32'(s3_dst_q) < NREG)) busy[s3_dst_q] = 1'b1;
  end

  always_comb begin
    run      = (state_q == StRun);
    hit_d    = busy[s0_d];
    hit_s    = busy[s0_s];
    squash_c = s2_taken & s2_q.v & s2_q.ctl;
    stall_c  = run & s0_valid & ~squash_c & ((s0_use_d & hit_d) | (s0_use_s & hit_s));
    issue_c  = run & s0_valid & ~stall_c & ~squash_c;
    fetch_c  = run & (squash_c | (~stall_c & ~(issue_c & s0_trap)));
    trap_squashed = squash_c & s1_q.v & s1_q.trap;
  end

  always_comb begin
    s1_d = '0;
    if (issue_c) begin
      s1_d.v    = 1'b1;
      s1_d.wr   = s0_wr;
      s1_d.ctl  = s0_ctl;
      s1_d.trap = s0_trap;
      s1_d.dst  = s0_d;
    end
    s2_d = squash_c ? '0 : s1_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (issue_c && s0_trap) state_d = StDrain;
      end
      StDrain: begin
        // Only an older branch can kill the trap, and only while it sits in stage 1.
        if (trap_squashed) begin
          state_d = StRun;
        end else if (s3_v_q && s3_trap_q) begin
          state_d = StHalt;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CntOne;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_v_q    <= 1'b0;
      s3_wr_q   <= 1'b0;
      s3_trap_q <= 1'b0;
      s3_dst_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_v_q    <= s2_q.v;
      s3_wr_q   <= s2_q.wr;
      s3_trap_q <= s2_q.trap;
      s3_dst_q  <= s2_q.dst;
      cnt_q     <= cnt_d;
    end
  end

  // Stage-0 inputs may be live during reset; keep the strobes quiet until release.
  always_comb begin
    fetch_en  = reset & fetch_c;
    issue     = reset & issue_c;
    stall     = reset & stall_c;
    squash    = reset & squash_c;
    halted    = (state_q == StHalt);
    stall_cnt = cnt_q;
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: directed scenarios plus a randomized run against an
// instruction-level model that tracks each issued instruction by its issue time.
module tb_pipe_hazard_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_valid, s0_use_d, s0_use_s, s0_wr, s0_ctl, s0_trap, s2_taken;
  logic [3:0]  s0_d, s0_s;
  logic        fetch_en, issue, stall, squash, halted;
  logic [15:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_hazard_ctl #(.NREG(16), .CNTW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .s0_valid (s0_valid),
    .s0_use_d (s0_use_d),
    .s0_use_s (s0_use_s),
    .s0_d     (s0_d),
    .s0_s     (s0_s),
    .s0_wr    (s0_wr),
    .s0_ctl   (s0_ctl),
    .s0_trap  (s0_trap),
    .s2_taken (s2_taken),
    .fetch_en (fetch_en),
    .issue    (issue),
    .stall    (stall),
    .squash   (squash),
    .halted   (halted),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // {fetch_en, issue, stall, squash, halted}
  wire [4:0] outs = {fetch_en, issue, stall, squash, halted};

  task automatic drive(input logic v, input logic ud, input logic us, input logic [3:0] d,
                       input logic [3:0] s, input logic wr, input logic ctl, input logic trap,
                       input logic tk);
    s0_valid = v;  s0_use_d = ud; s0_use_s = us; s0_d = d; s0_s = s;
    s0_wr = wr; s0_ctl = ctl; s0_trap = trap; s2_taken = tk;
  endtask

  task automatic idle(input logic tk);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, tk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    #3;
    n_chk++;
    if (outs !== 5'b00000) $display("FAIL reset_outs: got %b want %b", outs, 5'b00000);
    else n_pass++;
    n_chk++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1'b0);
    #3;
    n_chk++;
    if (outs !== 5'b10000) $display("FAIL reset_release: got %b want %b", outs, 5'b10000);
    else n_pass++;
    tick();
  endtask

  task automatic test_independent();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 4'(i), 4'(8 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      n_chk++;
      if (outs !== 5'b11000) $display("FAIL indep_issue[%0d]: got %b want %b", i, outs, 5'b11000);
      else n_pass++;
      tick();
    end
    idle(1'b0);
    #3;
    n_chk++;
    if (stall_cnt !== 16'd0) $display("FAIL indep_cnt: got %0d want 0", stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_raw();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    n_chk++;
    if (outs !== 5'b11000) $display("FAIL raw_prod: got %b want %b", outs, 5'b11000);
    else n_pass++;
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, 1'b0, 1'b1, 4'd9, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      n_chk++;
      if (c < 4 && outs !== 5'b00100) $display("FAIL raw_stall[%0d]: got %b want %b", c, outs, 5'b00100);
      else if (c == 4 && outs !== 5'b11000) $display("FAIL raw_issue: got %b want %b", outs, 5'b11000);
      else n_pass++;
      tick();
    end
    idle(1'b0);
    #3;
    n_chk++;
    if (stall_cnt !== 16'd3) $display("FAIL raw_cnt: got %0d want 3", stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_squash_over_stall();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    n_chk++;
    if (outs !== 5'b00100) $display("FAIL sq_prestall: got %b want %b", outs, 5'b00100);
    else n_pass++;
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    n_chk++;
    if (outs !== 5'b10010) $display("FAIL sq_win: got %b want %b", outs, 5'b10010);
    else n_pass++;
    tick();
    // Stage 2 is now a bubble: taken is ignored and the writer has retired.
    #3;
    n_chk++;
    if (outs !== 5'b11000) $display("FAIL sq_after: got %b want %b", outs, 5'b11000);
    else n_pass++;
    n_chk++;
    if (stall_cnt !== 16'd1) $display("FAIL sq_cnt: got %0d want 1", stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_trap_drain();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    n_chk++;
    if (outs !== 5'b01000) $display("FAIL trap_issue: got %b want %b", outs, 5'b01000);
    else n_pass++;
    tick();
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      n_chk++;
      if (c <= 3 && outs !== 5'b00000) $display("FAIL trap_drain[%0d]: got %b want %b", c, outs, 5'b00000);
      else if (c > 3 && outs !== 5'b00001) $display("FAIL trap_halt[%0d]: got %b want %b", c, outs, 5'b00001);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_squashed_trap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #3;
    n_chk++;
    if (outs !== 5'b01000) $display("FAIL strap_issue: got %b want %b", outs, 5'b01000);
    else n_pass++;
    tick();
    idle(1'b1);
    #3;
    n_chk++;
    if (outs !== 5'b00010) $display("FAIL strap_squash: got %b want %b", outs, 5'b00010);
    else n_pass++;
    tick();
    idle(1'b0);
    #3;
    n_chk++;
    if (outs !== 5'b10000) $display("FAIL strap_run: got %b want %b", outs, 5'b10000);
    else n_pass++;
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #3;
    n_chk++;
    if (outs !== 5'b11000) $display("FAIL strap_reissue: got %b want %b", outs, 5'b11000);
    else n_pass++;
    tick();
    idle(1'b0);
    repeat (4) tick();
    #3;
    n_chk++;
    if (halted !== 1'b0) $display("FAIL strap_halted: got %b want 0", halted);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    #3;
    n_chk++;
    if ({stall, stall_cnt} !== {1'b1, 16'd2}) $display("FAIL rms_pre: got stall=%b cnt=%0d want stall=1 cnt=2", stall, stall_cnt);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_chk++;
    if ({outs, stall_cnt} !== 21'd0) $display("FAIL rms_reset: got outs=%b cnt=%0d want 0", outs, stall_cnt);
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #3;
    n_chk++;
    if ({outs, stall_cnt} !== {5'b11000, 16'd0}) $display("FAIL rms_after: got outs=%b cnt=%0d want 11000 cnt=0", outs, stall_cnt);
    else n_pass++;
    tick();
  endtask

  // Reference model: one record per issued instruction; its stage is derived from issue time.
  typedef struct {
    int       t;
    bit       wr, ctl, trap, dead;
    bit [3:0] dst;
  } rec_t;

  task automatic test_random();
    rec_t q[$];
    int   now = 0, m_cnt = 0, halt_age = 0;
    bit   m_drain = 0, m_halt = 0;
    bit   v, ud, us, wr, ctl, trap, tk, sq, hd, hs, trap3, run;
    bit   e_stall, e_issue, e_fetch;
    bit [3:0] d, s;
    rec_t nr;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_halt && halt_age >= 3) begin
        do_reset();
        q.delete();
        now = 0; m_cnt = 0; halt_age = 0; m_drain = 0; m_halt = 0;
      end
      v = ($urandom_range(0, 3) != 0);
      ud = 1'($urandom); us = 1'($urandom); wr = 1'($urandom);
      d = 4'($urandom_range(0, 15)); s = 4'($urandom_range(0, 15));
      ctl = ($urandom_range(0, 3) == 0);
      trap = ($urandom_range(0, 39) == 0);
      tk = ($urandom_range(0, 2) == 0);
      drive(v, ud, us, d, s, wr, ctl, trap, tk);
      sq = 0; hd = 0; hs = 0; trap3 = 0;
      foreach (q[i]) begin
        if (!q[i].dead) begin
          if (now - q[i].t + 1 == 2 && q[i].ctl && tk) sq = 1;
          if (now - q[i].t + 1 == 3 && q[i].trap) trap3 = 1;
          if (q[i].wr && q[i].dst == d) hd = 1;
          if (q[i].wr && q[i].dst == s) hs = 1;
        end
      end
      run = !m_drain && !m_halt;
      e_stall = run && v && !sq && ((ud && hd) || (us && hs));
      e_issue = run && v && !e_stall && !sq;
      e_fetch = run && (sq || (!e_stall && !(e_issue && trap)));
      #3;
      n_chk++;
      if (outs !== {e_fetch, e_issue, e_stall, sq, m_halt})
        $display("FAIL rand_outs cyc %0d: got %b want %b", cyc, outs,
                 {e_fetch, e_issue, e_stall, sq, m_halt});
      else n_pass++;
      n_chk++;
      if (stall_cnt !== 16'(m_cnt)) $display("FAIL rand_cnt cyc %0d: got %0d want %0d", cyc, stall_cnt, m_cnt);
      else n_pass++;
      if (e_stall && m_cnt < 65535) m_cnt++;
      if (sq) begin
        foreach (q[i]) begin
          if (now - q[i].t + 1 == 1 && !q[i].dead) begin
            q[i].dead = 1;
            if (q[i].trap) m_drain = 0;
          end
        end
      end else if (m_drain && trap3) begin
        m_drain = 0;
        m_halt = 1;
      end
      if (e_issue) begin
        nr.t = now + 1; nr.wr = wr; nr.ctl = ctl; nr.trap = trap; nr.dst = d; nr.dead = 0;
        q.push_back(nr);
        if (trap) m_drain = 1;
      end
      if (m_halt) halt_age++;
      now++;
      while (q.size() > 0 && now - q[0].t + 1 > 3) void'(q.pop_front());
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    idle(1'b0);
    test_reset();
    test_independent();
    test_raw();
    test_squash_over_stall();
    test_trap_drain();
    test_squashed_trap();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Issue and interlock controller for the 16-bit four-stage pipeline: stage 0 fetch/decode, stage 1 register read, stage 2 ALU/memory/branch resolve, stage 3 register writeback. It keeps a shadow scoreboard of the destinations in flight. From that it decides each cycle whether the stage-0 instruction issues, stalls or is squashed. It also sequences the trap drain into `halted`. The controller holds no datapath state: the pipeline registers load from its `fetch_en`/`issue`/`squash` outputs.

## Interface
Parameters:
- `NREG`, default 16: number of architectural registers. All are writable; there is no hardwired zero.
- `CNTW`, default 16: width of the stall performance counter.

Ports:
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `s0_valid`, in, 1: stage 0 holds a decoded instruction.
- `s0_use_d`, in, 1: the instruction reads `r[rd]`.
- `s0_use_s`, in, 1: the instruction reads `r[rs]`.
- `s0_d`, in, 4: rd field.
- `s0_s`, in, 4: rs field.
- `s0_wr`, in, 1: the instruction writes `r[rd]`.
- `s0_ctl`, in, 1: control transfer (bz/bnz/jr).
- `s0_trap`, in, 1: trap opcode.
- `s2_taken`, in, 1: the control instruction in stage 2 redirects the PC this cycle.
- `fetch_en`, out, 1: PC advances and stage 0 reloads.
- `issue`, out, 1: the stage-0 instruction moves into stage 1 at this edge.
- `stall`, out, 1: a RAW hazard holds stage 0.
- `squash`, out, 1: stages 0 and 1 are killed and the PC loads the branch target.
- `halted`, out, 1: the trap has retired.
- `stall_cnt`, out, CNTW: saturating count of stalled cycles.

## Operation
- Shadow stages k=1..3 each hold `{v_k, wr_k, ctl_k, trap_k, dst_k[3:0]}`. Every edge shifts 3←2 and 2←1. Stage 1 loads the stage-0 fields when `issue`=1, otherwise a bubble (all v/flags 0).
- `hit(r)` = OR over k=1..3 of (`v_k & wr_k & dst_k==r`). The register file has no write-through, so stage 3 counts as a hit.
- `stall` = `state==RUN & s0_valid & !squash & ((s0_use_d & hit(s0_d)) | (s0_use_s & hit(s0_s)))`.
- `squash` = `s2_taken & v2 & ctl2`. If `s2_taken` is asserted while stage 2 is not a valid control instruction, it is ignored.
- When `squash`=1: stage 2 receives a bubble instead of stage 1, stage 1 receives a bubble, and `issue`=0. Squash wins over stall and over trap.
- `issue` = `state==RUN & s0_valid & !stall & !squash`.
- `fetch_en` = `state==RUN & (squash | (!stall & !(issue & s0_trap)))`.
- FSM, 2-bit:
  - RUN→DRAIN when `issue & s0_trap`.
  - DRAIN→RUN when `squash` kills the trap while it is in stage 1. A trap in stage 2 or 3 cannot be squashed, because only older instructions can squash it.
  - DRAIN→HALT when `v3 & trap3`.
  - HALT is terminal until reset.
  - In DRAIN and HALT: `issue`=0 and `fetch_en`=0. Stage-0 inputs are ignored.
- `halted` = `state==HALT`, registered.
- `stall_cnt` increments on each edge where `stall`=1 and saturates at all-ones.

## Timing
- Reset low, asynchronous:
  - state=RUN, all `v_k`=0, `stall_cnt`=0.
  - `fetch_en`, `issue`, `stall`, `squash`, `halted` forced to 0 while `reset` is low.
  - `fetch_en`=1 in the first cycle after release.
  - Reset mid-stall or mid-drain discards all in-flight state.
- The producer/consumer issue gap is 4 cycles. A consumer immediately behind its producer stalls 3 cycles and issues on the 4th.
- Branch penalty is 2 bubbles, with the taken branch resolved in stage 2.
- `halted` rises 4 edges after the trap's issue edge, counting the issue edge as edge 1.
- Every output except `halted` and `stall_cnt` is combinational from inputs and shadow state, valid within the same cycle.

## Test plan
- Independent stream:
  - Stimulus: 8 instructions with `s0_wr`=1 and distinct `s0_d` 0..7, each reading an unwritten register.
  - Required: `issue`=1 on 8 consecutive cycles; `stall` never asserts; `stall_cnt`=0.
- RAW on rs:
  - Stimulus: A writes r3; the next instruction has `s0_use_s`=1, `s0_s`=3.
  - Required: `stall`=1 for exactly 3 cycles and `fetch_en`=0 during them; B issues on the 4th cycle; `stall_cnt`=3.
- Squash over stall:
  - Stimulus: taken branch reaches stage 2 (`s2_taken`=1) while stage 0 is stalled on a stage-3 writer.
  - Required: `squash`=1, `stall`=0, `issue`=0, `fetch_en`=1; next cycle v1=v2=0.
- Trap drain:
  - Stimulus: trap issues at edge 1.
  - Required: `fetch_en`=0 from edge 1 onward; `halted`=1 after edge 4; further `s0_valid` pulses never issue.
- Squashed trap:
  - Stimulus: trap in stage 1 with a taken branch in stage 2.
  - Required: state returns to RUN, `fetch_en`=1, `halted` stays 0.
- Reset mid-stall:
  - Stimulus: drop `reset` during a 3-cycle stall with `stall_cnt`=2.
  - Required: outputs go to 0 immediately; after release a previously conflicting instruction issues with no stall and `stall_cnt`=0.
